// File: rtl/sw_debounce_n.sv
// sw_debounce_n: multi-channel counter-based switch debouncer with press/release/long/repeat pulses
// Ports: clk, rst_n (async, active-low); i_sw raw switch pins; i_repeat_en per-channel auto-repeat enable;
//        o_level debounced level (1 = pressed); o_press/o_release/o_long/o_repeat single-clk event pulses.
module sw_debounce_n #(
  parameter int N_CH       = 3,
  parameter int TICK_DIV   = 500000,
  parameter int STABLE_CNT = 4,
  parameter int LONG_CNT   = 100,
  parameter int REPEAT_CNT = 20,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] i_sw,
  input  logic [N_CH-1:0] i_repeat_en,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_repeat
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(STABLE_CNT + 1);
  localparam int HW = $clog2(LONG_CNT + 1);
  localparam int RW = $clog2(REPEAT_CNT + 1);
  localparam logic [N_CH-1:0] IDLE = {N_CH{ACTIVE_LOW}};
  typedef enum logic [1:0] {RELEASED, PRESSED, HELD} state_t;
  logic [N_CH-1:0] sync1, sync2, s;
  logic [TW-1:0] tick_cnt;
  logic tick;
  assign tick = tick_cnt == TW'(TICK_DIV - 1);
  // s is normalised so that 1 always means pressed, whatever the pin polarity
  assign s = ACTIVE_LOW ? ~sync2 : sync2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1    <= IDLE;
      sync2    <= IDLE;
      tick_cnt <= '0;
    end else begin
      sync1    <= i_sw;
      sync2    <= sync1;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t state;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic level, press_p, rel_p, long_p, rep_p, acc;
    // acc: this tick completes the run of differing samples, so the level flips now
    assign acc = tick && s[c] != level && db_cnt == DW'(STABLE_CNT - 1);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        state    <= RELEASED;
        db_cnt   <= '0;
        hold_cnt <= '0;
        rep_cnt  <= '0;
        level    <= 1'b0;
        press_p  <= 1'b0;
        rel_p    <= 1'b0;
        long_p   <= 1'b0;
        rep_p    <= 1'b0;
      end else begin
        press_p <= acc && !level;
        rel_p   <= acc && level;
        long_p  <= 1'b0;
        rep_p   <= 1'b0;
        if (tick) begin
          db_cnt <= (s[c] == level || acc) ? '0 : db_cnt + DW'(1);
          if (acc) level <= !level;
          // an accepted release is checked first so it beats a coincident long/repeat threshold
          case (state)
            RELEASED: if (acc) begin
              state    <= PRESSED;
              hold_cnt <= '0;
            end
            PRESSED: if (acc) state <= RELEASED;
              else if (hold_cnt == HW'(LONG_CNT - 1)) begin
                long_p  <= 1'b1;
                state   <= HELD;
                rep_cnt <= '0;
              end else hold_cnt <= hold_cnt + HW'(1);
            HELD: if (acc) state <= RELEASED;
              else if (!i_repeat_en[c]) rep_cnt <= '0;
              else if (rep_cnt == RW'(REPEAT_CNT - 1)) begin
                rep_p   <= 1'b1;
                rep_cnt <= '0;
              end else rep_cnt <= rep_cnt + RW'(1);
            default: state <= RELEASED;
          endcase
        end
      end
    assign o_level[c]   = level;
    assign o_press[c]   = press_p;
    assign o_release[c] = rel_p;
    assign o_long[c]    = long_p;
    assign o_repeat[c]  = rep_p;
  end
endmodule

// File: tb/tb_sw_debounce_n.sv
// tb_sw_debounce_n: scoreboard bench for sw_debounce_n with directed switch vectors
module tb_sw_debounce_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] i_sw = 3'b111;
  logic [2:0] i_repeat_en = 3'b000;
  logic [2:0] o_level, o_press, o_release, o_long, o_repeat;
  int cyc = 0;
  int last_evt = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string      name;
    logic [2:0] pr, rl, lg, rp, lv;
    bit         rel;
    int         base, lo, hi;
  } exp_t;
  exp_t q[$];

  sw_debounce_n #(
    .N_CH(3), .TICK_DIV(4), .STABLE_CNT(3), .LONG_CNT(5), .REPEAT_CNT(2), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_sw(i_sw), .i_repeat_en(i_repeat_en),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_repeat(o_repeat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // each popped event is checked for pulse pattern, level and its delay from a base point
  always @(negedge clk)
    if (rst_n && (o_press | o_release | o_long | o_repeat) != 3'b000) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b long=%b repeat=%b",
                 cyc, o_press, o_release, o_long, o_repeat);
      end else begin
        exp_t e;
        int d;
        e = q.pop_front();
        d = cyc - (e.rel ? last_evt : e.base);
        if (o_press !== e.pr || o_release !== e.rl || o_long !== e.lg || o_repeat !== e.rp ||
            o_level !== e.lv || d < e.lo || d > e.hi) begin
          errors++;
          $display("FAIL %s got press=%b release=%b long=%b repeat=%b level=%b delay=%0d, want press=%b release=%b long=%b repeat=%b level=%b delay=%0d..%0d",
                   e.name, o_press, o_release, o_long, o_repeat, o_level, d,
                   e.pr, e.rl, e.lg, e.rp, e.lv, e.lo, e.hi);
        end
        last_evt = cyc;
      end
    end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input logic [2:0] pr, rl, lg, rp, lv,
                      input bit rel, input int lo, input int hi);
    exp_t e;
    e.name = n; e.pr = pr; e.rl = rl; e.lg = lg; e.rp = rp; e.lv = lv;
    e.rel = rel; e.base = cyc; e.lo = lo; e.hi = hi;
    q.push_back(e);
  endtask

  task automatic check_out(input string n, input logic [14:0] want);
    checks++;
    if ({o_level, o_press, o_release, o_long, o_repeat} !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", n, {o_level, o_press, o_release, o_long, o_repeat}, want);
    end
  endtask

  // press then release well before the long-press threshold
  task automatic press_release(input int ch);
    logic [2:0] m;
    m = 3'(1 << ch);
    push("press", m, 3'b000, 3'b000, 3'b000, m, 1'b0, 11, 15);
    i_sw[ch] = 1'b0;
    step(16);
    push("release", 3'b000, m, 3'b000, 3'b000, 3'b000, 1'b0, 11, 15);
    i_sw[ch] = 1'b1;
    step(30);
  endtask

  initial begin
    step(3);
    check_out("reset_state", 15'd0);
    rst_n = 1'b1;
    step(200);
    check_out("idle", 15'd0);
    press_release(0);
    for (int i = 0; i < 10; i++) begin
      i_sw[1] = 1'b0;
      step(7);
      i_sw[1] = 1'b1;
      step(5);
    end
    step(20);
    check_out("bounce_level", 15'd0);
    press_release(1);
    i_repeat_en = 3'b100;
    push("press_ch2", 3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 1'b0, 11, 15);
    push("long_ch2", 3'b000, 3'b000, 3'b100, 3'b000, 3'b100, 1'b1, 20, 20);
    for (int i = 0; i < 3; i++)
      push("repeat_ch2", 3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 1'b1, 8, 8);
    i_sw[2] = 1'b0;
    step(60);
    i_repeat_en = 3'b000;
    step(40);
    push("release_ch2", 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 1'b0, 11, 15);
    i_sw[2] = 1'b1;
    step(30);
    push("press_hold_ch0", 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 1'b0, 11, 15);
    push("long_ch0", 3'b000, 3'b000, 3'b001, 3'b000, 3'b001, 1'b1, 20, 20);
    i_sw[0] = 1'b0;
    step(40);
    rst_n = 1'b0;
    #1;
    check_out("reset_mid_hold", 15'd0);
    step(3);
    rst_n = 1'b1;
    push("repress_ch0", 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 1'b0, 11, 15);
    push("relong_ch0", 3'b000, 3'b000, 3'b001, 3'b000, 3'b001, 1'b1, 20, 20);
    step(40);
    push("rerelease_ch0", 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 11, 15);
    i_sw[0] = 1'b1;
    step(30);
    push("press_all", 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 1'b0, 11, 15);
    i_sw = 3'b000;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        step(1);
        got = o_press == 3'b111;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL press_all_wait got o_press never 111 within 20 clk want 111");
      end
    end
    // release lands on the tick that would otherwise report long-press
    step(7);
    push("release_all_on_long", 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 20, 20);
    i_sw = 3'b111;
    step(60);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d outstanding want 0 (next %s)", q.size(), q[0].name);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sw_debounce_n.md
# sw_debounce_n

Parametrised multi-channel push-button conditioner for the board switch inputs. It replaces the two-flop edge filter with a counter-based debouncer on every channel. Each channel provides a stable level, press and release pulses, long-press detection and optional auto-repeat. It runs entirely on clk with one internal sample-tick enable, so no derived clocks are needed. Its outputs feed controller-style mode/position/setup logic directly as single-cycle enables.

## Interface
- N_CH, 3, number of independent switch channels (≥1)
- TICK_DIV, 500000, clk cycles per sample tick (≥2; 100 Hz at 50 MHz)
- STABLE_CNT, 4, consecutive differing samples required to accept a level change (≥1)
- LONG_CNT, 100, ticks after press before long-press is reported (≥1)
- REPEAT_CNT, 20, ticks between auto-repeat pulses (≥1)
- ACTIVE_LOW, 1, 1: a pressed switch reads 0 on i_sw; 0: a pressed switch reads 1
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- i_sw  input  N_CH  raw asynchronous switch pins
- i_repeat_en  input  N_CH  per-channel auto-repeat enable, sampled on ticks
- o_level  output  N_CH  debounced level, 1 = pressed
- o_press  output  N_CH  1-clk pulse on accepted press
- o_release  output  N_CH  1-clk pulse on accepted release
- o_long  output  N_CH  1-clk pulse when hold reaches LONG_CNT ticks
- o_repeat  output  N_CH  1-clk pulse every REPEAT_CNT ticks in long-hold while enabled

## Operation
- **Synchroniser.** Each i_sw bit passes through 2 flops that reset to the inactive level (ACTIVE_LOW ? 1 : 0). The result is normalised so that s = 1 means pressed.
- **Tick generator.**
  - tick_cnt counts 0..TICK_DIV-1 and wraps to 0. It is shared by all channels.
  - tick is high in the cycle where tick_cnt == TICK_DIV-1.
  - Counter width is $clog2(TICK_DIV).
- **Debounce counter.** Each channel has db_cnt of width $clog2(STABLE_CNT+1). On each tick:
  - s == o_level: db_cnt is cleared.
  - s != o_level and db_cnt == STABLE_CNT-1: o_level toggles, db_cnt is cleared, and o_press or o_release pulses.
  - Otherwise db_cnt increments.
- **Per-channel FSM.** Transitions are evaluated on ticks only.
  - RELEASED: an accepted press moves to PRESSED and clears hold_cnt.
  - PRESSED: an accepted release moves to RELEASED. Otherwise hold_cnt increments; at hold_cnt == LONG_CNT-1 the FSM pulses o_long, moves to HELD and clears rep_cnt.
  - HELD: an accepted release moves to RELEASED. Otherwise, if i_repeat_en is 1, rep_cnt increments; at REPEAT_CNT-1 it pulses o_repeat and clears rep_cnt. If i_repeat_en is 0, rep_cnt is cleared and no pulse is produced.
- **Priority.** An accepted release on the same tick as the long or repeat threshold wins: only o_release pulses.
- **Independence.** Channels are fully independent. Simultaneous events on several channels pulse in the same cycle.

## Timing
- **Reset.** Asserting rst_n immediately clears:
  - all outputs to 0;
  - all states to RELEASED;
  - all counters to 0;
  - sync flops to the inactive level.
- **After reset.** No pulse is generated unless a new change is accepted. A switch held through reset is reported as a fresh press after STABLE_CNT ticks plus sync delay.
- **Pulse timing.** All outputs are registered. A pulse appears in the cycle after the deciding tick cycle and is high for exactly 1 clk, because TICK_DIV ≥ 2.
- **Press latency.** From a clean pin change to o_press/o_level: ≥ 2 + (STABLE_CNT-1)·TICK_DIV + 1 clk and ≤ 2 + STABLE_CNT·TICK_DIV + 1 clk.
- **Long-press timing.** o_long comes exactly LONG_CNT·TICK_DIV clk after o_press. The first o_repeat comes REPEAT_CNT·TICK_DIV clk after o_long, then repeats at that period.
- **Bounce rejection.** A sample that matches o_level before the count completes restarts the count. Any excursion shorter than (STABLE_CNT-1)·TICK_DIV clk is never reported.
- **i_repeat_en.** A change takes effect at the next tick. A re-enable restarts the repeat period from 0.

## Test plan
Bench parameters: N_CH=3, TICK_DIV=4, STABLE_CNT=3, LONG_CNT=5, REPEAT_CNT=2, ACTIVE_LOW=1.
- **Idle after reset:** rst_n low then high, i_sw=3'b111 for 200 clk → all outputs stay 0.
- **Clean press/release on ch0:** i_sw[0]→0 → o_press=3'b001 for 1 clk, 11–15 clk after the edge, o_level=3'b001. Then i_sw[0]→1 → o_release=3'b001 with the same latency, o_level=0.
- **Bounce on ch1:** i_sw[1] low 7 clk / high 5 clk, repeated 10× → no o_press[1]. Then held low → o_press[1] once.
- **Long/repeat on ch2:**
  - i_repeat_en=3'b100, hold ch2 → o_long[2] 20 clk after o_press[2], then o_repeat[2] every 8 clk.
  - Drop i_repeat_en → repeats stop.
  - Release → o_release[2] only.
- **Reset mid-hold:** rst_n low while ch0 is in HELD → o_level=0 at once. After reset release, with the pin still low → a single o_press[0] within 15 clk and no o_release.
- **Simultaneous press:** i_sw 3'b111→3'b000 in one cycle → o_press=3'b111 in a single cycle. Release on the same tick as the long threshold → o_release only, no o_long.
